// File: rtl/cpu_bus_sync.sv
// -----------------------------------------------------------------------------
// cpu_bus_sync
//   Brings the raw, asynchronous CPU bus (address, data, active-low strobes)
//   into the clk28 domain. It synchronises the strobes, qualifies them into
//   request flags and edge pulses, and tracks the current bus-cycle type with a
//   small FSM. A cycle-length counter runs for the duration of each bus cycle.
//
//   Optional feature macro: CPU_BUS_FILTER_EN
//     defined   : each synchronised strobe passes through a glitch filter. The
//                 filter needs FILT_LEN stable clocks and adds FILT_LEN-1 clocks
//                 of latency.
//     undefined : no filter. The strobe latency is SYNC_STAGES clocks.
//
// Ports
//   clk28, rst_n                 clock, asynchronous active-low reset
//   a_in[ADDR_W], d_in[8]        raw CPU address / data pins
//   n_iorq..n_wr                 raw active-low CPU strobes
//   a_raw                        a_in passed straight through
//   a, d                         registered address (held in a cycle) / data
//   iorq, mreq, m1, rfsh, rd, wr synchronised active-high strobes
//   ioreq, memreq, inta          qualified request flags
//   memreq_rise, ioreq_rise,     one-clock edge pulses
//   req_fall
//   cycle[3]                     bus-cycle code (IDLE=0 .. INTA=5)
//   cycle_len[CNT_W]             clocks spent in the current non-idle cycle
// -----------------------------------------------------------------------------
module cpu_bus_sync #(
  parameter int ADDR_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int CNT_W       = 8
) (
  input  logic              clk28,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] a_in,
  input  logic [7:0]        d_in,
  input  logic              n_iorq,
  input  logic              n_mreq,
  input  logic              n_m1,
  input  logic              n_rfsh,
  input  logic              n_rd,
  input  logic              n_wr,
  output logic [ADDR_W-1:0] a_raw,
  output logic [ADDR_W-1:0] a,
  output logic [7:0]        d,
  output logic              iorq,
  output logic              mreq,
  output logic              m1,
  output logic              rfsh,
  output logic              rd,
  output logic              wr,
  output logic              ioreq,
  output logic              memreq,
  output logic              inta,
  output logic              memreq_rise,
  output logic              ioreq_rise,
  output logic              req_fall,
  output logic [2:0]        cycle,
  output logic [CNT_W-1:0]  cycle_len
);

  // Bit positions of the strobes inside the packed strobe vectors.
  localparam int S_IORQ = 0;
  localparam int S_MREQ = 1;
  localparam int S_M1   = 2;
  localparam int S_RFSH = 3;
  localparam int S_RD   = 4;
  localparam int S_WR   = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MEMRD = 3'd1,
    ST_MEMWR = 3'd2,
    ST_IORD  = 3'd3,
    ST_IOWR  = 3'd4,
    ST_INTA  = 3'd5
  } cycle_e;

  // Reject illegal parameter values at elaboration.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("cpu_bus_sync: SYNC_STAGES must be >= 2");
  end
  if (FILT_LEN < 1) begin : g_bad_filt
    $error("cpu_bus_sync: FILT_LEN must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Strobe synchroniser: invert to active-high, then SYNC_STAGES flops.
  // ---------------------------------------------------------------------------
  logic [5:0] raw_act;
  logic [5:0] sync_q [SYNC_STAGES];
  logic [5:0] strb;     // final synchronised (and optionally filtered) strobes

  assign raw_act = ~{n_wr, n_rd, n_rfsh, n_m1, n_mreq, n_iorq};

  // NOTE: the synchroniser array is a bank of ordinary flops, not a RAM, so
  // every element is reset. This keeps the strobes inactive during reset.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw_act;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef CPU_BUS_FILTER_EN
  // Glitch filter. filt_q holds the accepted level of each strobe. fcnt_q
  // counts how many consecutive clocks the last sync stage has disagreed with
  // it. The new level is let through combinationally on the FILT_LEN-th
  // disagreeing clock, and is committed to filt_q on the next edge. This gives
  // exactly FILT_LEN-1 clocks of extra latency.
  localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FCW-1:0] FCNT_LAST = FCW'(FILT_LEN - 1);

  logic [5:0]     sync_last;
  logic [5:0]     filt_q;
  logic [FCW-1:0] fcnt_q [6];

  assign sync_last = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      for (int i = 0; i < 6; i++) fcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (sync_last[i] != filt_q[i]) begin
          if (fcnt_q[i] == FCNT_LAST) begin
            filt_q[i] <= sync_last[i];
            fcnt_q[i] <= '0;
          end else begin
            fcnt_q[i] <= fcnt_q[i] + 1'b1;
          end
        end else begin
          fcnt_q[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    strb = filt_q;
    for (int i = 0; i < 6; i++) begin
      if (sync_last[i] != filt_q[i] && fcnt_q[i] == FCNT_LAST) strb[i] = sync_last[i];
    end
  end
`else
  assign strb = sync_q[SYNC_STAGES-1];
`endif

  assign iorq = strb[S_IORQ];
  assign mreq = strb[S_MREQ];
  assign m1   = strb[S_M1];
  assign rfsh = strb[S_RFSH];
  assign rd   = strb[S_RD];
  assign wr   = strb[S_WR];

  // ---------------------------------------------------------------------------
  // Qualified requests and edge pulses
  // ---------------------------------------------------------------------------
  logic memreq_prev_q, ioreq_prev_q, any_prev_q;
  logic any_req;

  assign ioreq   = iorq & ~m1 & (rd | wr);
  assign memreq  = mreq & ~rfsh & (rd | wr);
  assign inta    = iorq & m1;
  assign any_req = memreq | ioreq | inta;

  // The history flops are cleared on reset. A request still held across
  // reset release is therefore seen as new, and an aborted cycle gives no
  // fall pulse.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      memreq_prev_q <= 1'b0;
      ioreq_prev_q  <= 1'b0;
      any_prev_q    <= 1'b0;
    end else begin
      memreq_prev_q <= memreq;
      ioreq_prev_q  <= ioreq;
      any_prev_q    <= any_req;
    end
  end

  assign memreq_rise = memreq & ~memreq_prev_q;
  assign ioreq_rise  = ioreq & ~ioreq_prev_q;
  assign req_fall    = any_prev_q & ~any_req;

  // ---------------------------------------------------------------------------
  // Bus-cycle FSM and cycle-length counter
  // ---------------------------------------------------------------------------
  cycle_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
    end else begin
      // NOTE: use non-blocking assignments for all clocked state. Every flop
      // then samples values from before the edge, whatever the statement order.
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  // NOTE: every output of this block gets a default first. This stops a
  // branch that leaves a signal unassigned from inferring a latch.
  always_comb begin
    state_d = state_q;
    len_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        // Priority: INTA > IO > MEM, and read before write.
        if (inta)                state_d = ST_INTA;
        else if (ioreq && rd)    state_d = ST_IORD;
        else if (ioreq && wr)    state_d = ST_IOWR;
        else if (memreq && rd)   state_d = ST_MEMRD;
        else if (memreq && wr)   state_d = ST_MEMWR;
        else                     state_d = ST_IDLE;
      end
      ST_MEMRD, ST_MEMWR: if (!memreq) state_d = ST_IDLE;
      ST_IORD,  ST_IOWR:  if (!ioreq)  state_d = ST_IDLE;
      ST_INTA:            if (!inta)   state_d = ST_IDLE;
      default:            state_d = ST_IDLE;
    endcase

    if (state_d != ST_IDLE) begin
      if (state_q == ST_IDLE)  len_d = CNT_W'(1);
      else if (len_q != '1)    len_d = len_q + 1'b1;
      else                     len_d = len_q;
    end
  end

  assign cycle     = state_q;
  assign cycle_len = len_q;

  // ---------------------------------------------------------------------------
  // Address / data registers
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] a_q;
  logic [7:0]        d_q;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      d_q <= '0;
    end else begin
      d_q <= d_in;
      if (state_q == ST_IDLE) a_q <= a_in;   // freeze address during a cycle
    end
  end

  assign a_raw = a_in;
  assign a     = a_q;
  assign d     = d_q;

endmodule

// File: tb/tb_cpu_bus_sync.sv
// -----------------------------------------------------------------------------
// tb_cpu_bus_sync
//   Directed self-checking bench for cpu_bus_sync. It drives the pins just
//   after a rising edge and samples 1 ns after each rising edge. The edge
//   pulses and the peak cycle_len are accumulated on every sampled clock.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cpu_bus_sync;

  localparam int ADDR_W = 16;
  localparam int SYNC   = 2;
  localparam int FILT   = 3;
  localparam int CNT_W  = 8;
`ifdef CPU_BUS_FILTER_EN
  localparam int LAT = SYNC + FILT - 1;
`else
  localparam int LAT = SYNC;
`endif

  logic              clk28 = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] a_in;
  logic [7:0]        d_in;
  logic n_iorq, n_mreq, n_m1, n_rfsh, n_rd, n_wr;
  logic [ADDR_W-1:0] a_raw, a;
  logic [7:0]        d;
  logic iorq, mreq, m1, rfsh, rd, wr;
  logic ioreq, memreq, inta;
  logic memreq_rise, ioreq_rise, req_fall;
  logic [2:0]        cycle;
  logic [CNT_W-1:0]  cycle_len;

  cpu_bus_sync #(
    .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC), .FILT_LEN(FILT), .CNT_W(CNT_W)
  ) dut (
    .clk28(clk28), .rst_n(rst_n), .a_in(a_in), .d_in(d_in),
    .n_iorq(n_iorq), .n_mreq(n_mreq), .n_m1(n_m1), .n_rfsh(n_rfsh),
    .n_rd(n_rd), .n_wr(n_wr),
    .a_raw(a_raw), .a(a), .d(d),
    .iorq(iorq), .mreq(mreq), .m1(m1), .rfsh(rfsh), .rd(rd), .wr(wr),
    .ioreq(ioreq), .memreq(memreq), .inta(inta),
    .memreq_rise(memreq_rise), .ioreq_rise(ioreq_rise), .req_fall(req_fall),
    .cycle(cycle), .cycle_len(cycle_len)
  );

  always #5 clk28 = ~clk28;

  int n_checks = 0;
  int n_pass   = 0;
  int mr_cnt, ir_cnt, rf_cnt, max_len;
  bit mreq_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
  endtask

  task automatic clear_counts();
    mr_cnt = 0; ir_cnt = 0; rf_cnt = 0; max_len = 0; mreq_seen = 1'b0;
  endtask

  // Advance n clocks, sampling 1 ns after each rising edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk28); #1;
      if (memreq_rise) mr_cnt++;
      if (ioreq_rise)  ir_cnt++;
      if (req_fall)    rf_cnt++;
      if (int'(cycle_len) > max_len) max_len = int'(cycle_len);
      if (mreq) mreq_seen = 1'b1;
    end
  endtask

  task automatic pins_idle();
    {n_iorq, n_mreq, n_m1, n_rfsh, n_rd, n_wr} = 6'b111111;
  endtask

  initial begin
    rst_n = 1'b0; a_in = 16'hABCD; d_in = 8'h5A; pins_idle();
    clear_counts();

    // ---- reset state ----
    step(2);
    check("rst_a",     a,         16'h0000);
    check("rst_d",     d,         8'h00);
    check("rst_cycle", cycle,     3'd0);
    check("rst_len",   cycle_len, 8'd0);
    check("rst_strb",  {iorq, mreq, m1, rfsh, rd, wr}, 6'b0);
    rst_n = 1'b1;

    // ---- address/data registers in IDLE ----
    step(1);
    check("d_reg",  d, 8'h5A);
    check("a_idle", a, 16'hABCD);
    d_in = 8'hC3; a_in = 16'h0F0F; #1;
    check("a_raw",  a_raw, 16'h0F0F);
    check("d_old",  d, 8'h5A);
    step(1);
    check("d_lat1", d, 8'hC3);

    // ---- memory read, pins low for 10 clocks ----
    clear_counts();
    a_in = 16'h4000; n_mreq = 1'b0; n_rd = 1'b0;
    step(LAT - 1);
    check("mrd_sync_pre", mreq, 1'b0);
    step(1);
    check("mrd_sync_lat", {mreq, rd, memreq, memreq_rise}, 4'b1111);
    step(1);
    check("mrd_cycle", cycle, 3'd1);
    check("mrd_len1",  cycle_len, 8'd1);
    check("mrd_a",     a, 16'h4000);
    step(10 - (LAT + 1));
    pins_idle(); a_in = 16'h5555;
    step(LAT);
    check("mrd_fall",   {req_fall, cycle}, {1'b1, 3'd1});
    check("mrd_a_held", a, 16'h4000);
    step(1);
    check("mrd_idle",   {cycle, cycle_len}, {3'd0, 8'd0});
    check("mrd_rises",  mr_cnt, 1);
    check("mrd_falls",  rf_cnt, 1);
    check("mrd_maxlen", max_len, 10);

    // ---- IO write, address changes mid-cycle ----
    clear_counts();
    a_in = 16'h00FE; n_iorq = 1'b0; n_wr = 1'b0;
    step(LAT + 1);
    check("iow_cycle", cycle, 3'd4);
    a_in = 16'h1234;
    step(3);
    check("iow_a_held", a, 16'h00FE);
    pins_idle();
    step(LAT + 1);
    check("iow_idle",  cycle, 3'd0);
    check("iow_a_last", a, 16'h00FE);
    step(1);
    check("iow_a_new", a, 16'h1234);
    check("iow_rises", ir_cnt, 1);
    check("iow_falls", rf_cnt, 1);

    // ---- interrupt acknowledge ----
    n_m1 = 1'b0; n_iorq = 1'b0;
    step(LAT);
    check("inta_flags", {inta, ioreq}, 2'b10);
    step(1);
    check("inta_cycle", cycle, 3'd5);
    pins_idle();
    step(LAT + 1);
    check("inta_idle", cycle, 3'd0);

    // ---- refresh is not a memory request ----
    clear_counts();
    n_mreq = 1'b0; n_rfsh = 1'b0; n_rd = 1'b0;
    step(LAT + 1);
    check("rfsh_memreq", {rfsh, memreq}, 2'b10);
    check("rfsh_cycle",  cycle, 3'd0);
    check("rfsh_rise",   mr_cnt, 0);
    pins_idle();
    step(LAT + 1);

    // ---- priority: IO over MEM, rd over wr ----
    n_iorq = 1'b0; n_mreq = 1'b0; n_rd = 1'b0; n_wr = 1'b0;
    step(LAT + 1);
    check("prio_iord", cycle, 3'd3);
    pins_idle();
    step(LAT + 1);
    n_mreq = 1'b0; n_rd = 1'b0; n_wr = 1'b0;
    step(LAT + 1);
    check("prio_memrd", cycle, 3'd1);
    pins_idle();
    step(LAT + 1);

    // ---- 300-clock memory write: counter saturates ----
    n_mreq = 1'b0; n_wr = 1'b0;
    step(300);
    check("sat_cycle", cycle, 3'd2);
    check("sat_len",   cycle_len, 8'd255);
    pins_idle();
    step(LAT + 1);
    check("sat_idle", {cycle, cycle_len}, {3'd0, 8'd0});

    // ---- reset during a memory read ----
    n_mreq = 1'b0; n_rd = 1'b0;
    step(LAT + 3);
    check("rstm_cycle", cycle, 3'd1);
    clear_counts();
    rst_n = 1'b0; #1;
    check("rstm_abort", {cycle, cycle_len, memreq}, {3'd0, 8'd0, 1'b0});
    step(2);
    rst_n = 1'b1;
    step(LAT);
    check("rstm_rise",   memreq_rise, 1'b1);
    step(1);
    check("rstm_reenter", cycle, 3'd1);
    check("rstm_nofall",  rf_cnt, 0);
    pins_idle();
    step(LAT + 2);

`ifdef CPU_BUS_FILTER_EN
    // ---- glitch filter (FILT_LEN = 3) ----
    clear_counts();
    n_mreq = 1'b0; step(1); n_mreq = 1'b1; step(LAT + 3);
    check("filt_glitch1", mreq_seen, 1'b0);
    n_mreq = 1'b0; step(2); n_mreq = 1'b1; step(LAT + 3);
    check("filt_glitch2", mreq_seen, 1'b0);
    n_mreq = 1'b0; step(3); n_mreq = 1'b1;
    step(SYNC - 2);
    check("filt_3clk_pre", mreq, 1'b0);
    step(1);
    check("filt_3clk", mreq, 1'b1);
    step(LAT + 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_bus_sync.md
CPU_BUS_SYNC -- requirements
Module: cpu_bus_sync

Interface
REQ-001 Parameter ADDR_W, default 16: width of address bus.
REQ-002 Parameter SYNC_STAGES, default 2 (min 2): synchroniser depth for strobes.
REQ-003 Parameter FILT_LEN, default 3 (min 1): glitch-filter stability count in clocks (used only under CPU_BUS_FILTER_EN).
REQ-004 Parameter CNT_W, default 8: width of cycle-length counter.
REQ-005 clk28  in  1  single system clock; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 a_in  in  ADDR_W  raw CPU address pins.
REQ-008 d_in  in  8  raw CPU data pins.
REQ-009 n_iorq, n_mreq, n_m1, n_rfsh, n_rd, n_wr  in  1 each  raw active-low CPU strobes, asynchronous to clk28.
REQ-010 a_raw  out  ADDR_W  a_in passed combinationally.
REQ-011 a  out  ADDR_W  registered address, held during a bus cycle.
REQ-012 d  out  8  registered data.
REQ-013 iorq, mreq, m1, rfsh, rd, wr  out  1 each  synchronised active-high strobes.
REQ-014 ioreq, memreq, inta  out  1 each  qualified request flags.
REQ-015 memreq_rise, ioreq_rise, req_fall  out  1 each  single-clock edge pulses.
REQ-016 cycle  out  3  current bus-cycle state code.
REQ-017 cycle_len  out  CNT_W  clocks elapsed in current non-idle cycle.

Function
REQ-018 Each strobe SHALL be inverted then passed through SYNC_STAGES flip-flops; synced output latency = SYNC_STAGES clocks from pin change.
REQ-019 ioreq SHALL = iorq & ~m1 & (rd | wr); memreq SHALL = mreq & ~rfsh & (rd | wr); inta SHALL = iorq & m1; all combinational from synced strobes.
REQ-020 memreq_rise / ioreq_rise SHALL pulse one clock when memreq / ioreq goes 0->1; req_fall SHALL pulse one clock when (memreq|ioreq|inta) goes 1->0.
REQ-021 d SHALL register d_in every clock (one-clock latency).
REQ-022 a SHALL register a_in every clock while cycle = IDLE and hold its value otherwise.
REQ-023 FSM states/codes: IDLE=0, MEMRD=1, MEMWR=2, IORD=3, IOWR=4, INTA=5; codes 6-7 SHALL never occur.
REQ-024 From IDLE: memreq&rd -> MEMRD; memreq&wr -> MEMWR; ioreq&rd -> IORD; ioreq&wr -> IOWR; inta -> INTA; priority on simultaneous: INTA > IO > MEM, rd > wr.
REQ-025 From any non-IDLE state: return to IDLE in the clock after its qualifying request deasserts; no direct state-to-state transitions.
REQ-026 cycle_len SHALL load 1 on entry to a non-IDLE state, increment each clock in it, saturate at all-ones, and be 0 in IDLE.
REQ-027 A request asserting in the same clock the FSM returns to IDLE SHALL be accepted on the following clock.

Reset
REQ-028 On rst_n low, asynchronously: all sync/filter flops to inactive (strobe outputs 0), a=0, d=0, cycle=IDLE, cycle_len=0, all pulses 0.
REQ-029 Reset mid-cycle SHALL abort to IDLE with no req_fall pulse; after release, a request already active SHALL be seen as new (rise pulse emitted).

Configuration
REQ-030 Macro CPU_BUS_FILTER_EN defined: each synced strobe output SHALL change only after the last sync stage holds the new value for FILT_LEN consecutive clocks (added latency FILT_LEN-1).
REQ-031 Macro undefined: no filter logic; FILT_LEN ignored; latency per REQ-018.

Verification
REQ-032 Memory read: n_mreq, n_rd low 10 clocks, a_in=16'h4000 -> memreq_rise once, cycle=1, a=16'h4000 held, cycle_len reaches 10-ish then req_fall once, cycle=0.
REQ-033 IO write with a_in changing mid-cycle 16'h00FE -> 16'h1234 -> a stays 16'h00FE until IDLE; ioreq_rise once, cycle=4.
REQ-034 INTA: n_m1, n_iorq low together -> inta=1, ioreq=0, cycle=5; refresh (n_mreq, n_rfsh low) -> memreq=0, cycle stays 0.
REQ-035 Filter on, FILT_LEN=3: 1-clock and 2-clock n_mreq glitches -> mreq stays 0; 3-clock low -> mreq=1 after SYNC_STAGES+2 clocks.
REQ-036 Cycle of 300 clocks with CNT_W=8 -> cycle_len saturates at 255.
REQ-037 rst_n low for 2 clocks during MEMRD -> cycle=0, cycle_len=0 immediately, no req_fall; on release with strobes still low -> memreq_rise fires.
